// File: rtl/vector_pair_fifo.sv
// vector_pair_fifo
//   Buffers (vector1, vector2) pairs from a producer and hands them to a
//   consumer that may stall. Each pair is stored as one packed entry
//   {vector1[0:W1-1], vector2[0:W2-1]} in a DEPTH-deep circular buffer and
//   returned unchanged. Bit i of each output vector equals bit i of the
//   captured input vector; the ascending ranges are not reversed.
//
// Handshake: a transfer happens on a rising clk edge when valid && ready are
//   both high. The producer holds in_valid and the data stable until the
//   transfer happens. The consumer may toggle out_ready freely. in_ready and
//   out_valid depend only on registered state, never on the partner's signal.
//
// Ports
//   clk, rst       clock; asynchronous active-high reset
//   flush          synchronous clear; a push or pop in the same cycle is dropped
//   in_valid       producer presents a pair on vector1/vector2
//   in_ready       FIFO not full (level != DEPTH)
//   vector1/2      input pair, ascending ranges, bit 0 is the MSB
//   out_valid      FIFO not empty (level != 0)
//   out_ready      consumer takes the head pair
//   out_vector1/2  head pair; reads all zero while the FIFO is empty
//   level          number of stored entries, 0..DEPTH
module vector_pair_fifo #(
  parameter int W1    = 2,
  parameter int W2    = 6,
  parameter int DEPTH = 4,
  parameter int LW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [0:W1-1] vector1,
  input  logic [0:W2-1] vector2,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [0:W1-1] out_vector1,
  output logic [0:W2-1] out_vector2,
  output logic [LW-1:0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = W1 + W2;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  logic [EW-1:0] r_mem [0:DEPTH-1];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [LW-1:0] r_level;

  logic          w_push;
  logic          w_pop;
  logic [EW-1:0] w_head;

  // A full FIFO refuses a push even when it pops in the same cycle. This keeps
  // in_ready independent of out_ready.
  assign in_ready  = (r_level != FULL_LEVEL);
  assign out_valid = (r_level != '0);
  assign level     = r_level;

  assign w_push = in_valid && in_ready;
  assign w_pop  = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      // The pointers are AW bits wide and DEPTH is a power of two, so the
      // increment wraps from DEPTH-1 to 0. The level tells full from empty.
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)      r_level <= r_level + 1'b1;
      else if (w_pop && !w_push) r_level <= r_level - 1'b1;
    end
  end

  // Storage needs no reset. The outputs are masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_push && !flush) r_mem[r_wptr] <= {vector1, vector2};
  end

  assign w_head = r_mem[r_rptr];

  // The slices copy bits by position, so the entry's MSB lands on
  // out_vector1[0]. The ascending order is kept.
  always_comb begin
    out_vector1 = '0;
    out_vector2 = '0;
    if (out_valid) begin
      out_vector1 = w_head[EW-1:W2];
      out_vector2 = w_head[W2-1:0];
    end
  end

endmodule

// File: tb/tb_vector_pair_fifo.sv
module tb_vector_pair_fifo;

  localparam int W1    = 2;
  localparam int W2    = 6;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH + 1);
  localparam int EW    = W1 + W2;
  localparam int BUDGET = 50;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [0:W1-1] vector1 = '0;
  logic [0:W2-1] vector2 = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [0:W1-1] out_vector1;
  logic [0:W2-1] out_vector2;
  logic [LW-1:0] level;

  vector_pair_fifo #(.W1(W1), .W2(W2), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .vector1(vector1), .vector2(vector2),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_vector1(out_vector1), .out_vector2(out_vector2),
    .level(level)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic check_en = 1'b0;

  logic [EW-1:0] exp_q[$];   // model contents, front = head
  logic [EW-1:0] got_q[$];   // pairs seen leaving the DUT
  logic [EW-1:0] sent_q[$];  // pairs for the push/pop phase, in push order

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A queue of pairs. A full queue refuses a push. Flush and reset empty it.
  always @(posedge clk or posedge rst) begin
    bit do_push, do_pop;
    if (rst) begin
      exp_q.delete();
    end else if (flush) begin
      exp_q.delete();
    end else begin
      do_pop  = (exp_q.size() != 0) && out_ready;
      do_push = in_valid && (exp_q.size() < DEPTH);
      if (do_pop)  void'(exp_q.pop_front());
      if (do_push) exp_q.push_back({vector1, vector2});
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    logic [EW-1:0] head;
    if (check_en) begin
      head = (exp_q.size() != 0) ? exp_q[0] : '0;
      chk("level", 32'(level), 32'(exp_q.size()));
      chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      chk("in_ready", 32'(in_ready), 32'(exp_q.size() != DEPTH));
      chk("out_vector1", 32'(out_vector1), 32'(head[EW-1:W2]));
      chk("out_vector2", 32'(out_vector2), 32'(head[W2-1:0]));
      if (out_valid && out_ready) got_q.push_back({out_vector1, out_vector2});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push(input logic [W1-1:0] v1, input logic [W2-1:0] v2);
    logic acc;
    acc = 1'b0;
    in_valid = 1'b1;
    vector1  = v1;
    vector2  = v2;
    for (int i = 0; i < BUDGET && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) chk("push_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic wait_empty();
    logic done;
    done = 1'b0;
    for (int i = 0; i < BUDGET && !done; i++) begin
      @(negedge clk);
      done = (level == '0);
    end
    if (!done) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [EW-1:0] exp_fill [5];
    exp_fill[0] = 8'b01_000001;
    exp_fill[1] = 8'b10_000010;
    exp_fill[2] = 8'b11_000011;
    exp_fill[3] = 8'b00_111111;
    exp_fill[4] = 8'b10_001001;

    // Reset then idle.
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_en = 1'b1;
    @(negedge clk);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_ov1", 32'(out_vector1), 32'd0);
    chk("rst_ov2", 32'(out_vector2), 32'd0);
    step();

    // Bit-order check.
    push(2'b10, 6'b100001);
    @(negedge clk);
    chk("bo_out_valid", 32'(out_valid), 32'd1);
    chk("bo_ov1_0", 32'(out_vector1[0]), 32'd1);
    chk("bo_ov1_1", 32'(out_vector1[1]), 32'd0);
    chk("bo_ov2_0", 32'(out_vector2[0]), 32'd1);
    chk("bo_ov2_5", 32'(out_vector2[5]), 32'd1);
    chk("bo_level", 32'(level), 32'd1);
    step();
    out_ready = 1'b1;
    wait_empty();
    step();
    out_ready = 1'b0;
    got_q.delete();

    // Fill to full. A fifth pair is held and must wait.
    push(2'd1, 6'd1);
    push(2'd2, 6'd2);
    push(2'd3, 6'd3);
    push(2'd0, 6'd63);
    in_valid = 1'b1;
    vector1  = 2'b10;
    vector2  = 6'b001001;
    repeat (2) begin
      @(negedge clk);
      chk("full_level", 32'(level), 32'd4);
      chk("full_in_ready", 32'(in_ready), 32'd0);
      step();
    end
    // The first pop comes while full. The held pair goes in only afterwards.
    out_ready = 1'b1;
    @(negedge clk);
    chk("full_pop_in_ready", 32'(in_ready), 32'd0);
    push(2'b10, 6'b001001);
    wait_empty();
    step();
    out_ready = 1'b0;
    chk("fill_drain_count", 32'(got_q.size()), 32'd5);
    for (int i = 0; i < 5 && i < got_q.size(); i++)
      chk($sformatf("fill_order_%0d", i), 32'(got_q[i]), 32'(exp_fill[i]));
    got_q.delete();

    // Simultaneous push/pop at level 2, crossing the pointer wrap.
    sent_q.delete();
    push(2'd1, 6'd10); sent_q.push_back({2'd1, 6'd10});
    push(2'd2, 6'd20); sent_q.push_back({2'd2, 6'd20});
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      vector1 = 2'(i % 4);
      vector2 = 6'(i * 5 + 3);
      sent_q.push_back({2'(i % 4), 6'(i * 5 + 3)});
      @(negedge clk);
      chk("pp_level", 32'(level), 32'd2);
      step();
    end
    in_valid = 1'b0;
    wait_empty();
    step();
    out_ready = 1'b0;
    chk("pp_count", 32'(got_q.size()), 32'd12);
    for (int i = 0; i < 12 && i < got_q.size(); i++)
      chk($sformatf("pp_order_%0d", i), 32'(got_q[i]), 32'(sent_q[i]));
    got_q.delete();

    // Flush at level 3 with a push in the same cycle.
    push(2'd1, 6'd5);
    push(2'd2, 6'd6);
    push(2'd3, 6'd7);
    flush    = 1'b1;
    in_valid = 1'b1;
    vector1  = 2'd3;
    vector2  = 6'd44;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("fl_level", 32'(level), 32'd0);
    chk("fl_out_valid", 32'(out_valid), 32'd0);
    chk("fl_ov1", 32'(out_vector1), 32'd0);
    chk("fl_ov2", 32'(out_vector2), 32'd0);
    step();
    @(negedge clk);
    chk("fl_absent", 32'(level), 32'd0);
    step();

    // Reset between clock edges at level 2.
    push(2'd2, 6'd33);
    push(2'd1, 6'd17);
    @(negedge clk);
    chk("mr_pre_level", 32'(level), 32'd2);
    #2 rst = 1'b1;
    #1;
    chk("mr_out_valid", 32'(out_valid), 32'd0);
    chk("mr_level", 32'(level), 32'd0);
    chk("mr_in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mr_after_level", 32'(level), 32'd0);
    step();

    // A push after the reset must still work.
    push(2'b01, 6'b110011);
    @(negedge clk);
    chk("post_ov1", 32'(out_vector1), 32'd1);
    chk("post_ov2", 32'(out_vector2), 32'h33);
    step();

    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
